// File: rtl/iom_wait_ctrl_if.sv
// -----------------------------------------------------------------------------
// iom_wait_ctrl_if
// Local-bus bundle between the 8086-style CPU model and iom_wait_ctrl.
//   master : CPU side, drives Address/BHE_n/Data_in/CS/ALE/RD/WR and receives
//            OE/WD/READY/Data_out/Data_oe/ERR.
//   slave  : controller side, the mirror image.
// Strobes RD, WR, BHE_n, OE and WD are active low. CS, ALE, READY, Data_oe and
// ERR are active high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface iom_wait_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] Address;
    logic              BHE_n;
    logic [DATA_W-1:0] Data_in;
    logic              CS;
    logic              ALE;
    logic              RD;
    logic              WR;
    logic              OE;
    logic              WD;
    logic              READY;
    logic [DATA_W-1:0] Data_out;
    logic              Data_oe;
    logic              ERR;

    modport master (
        output Address, BHE_n, Data_in, CS, ALE, RD, WR,
        input  OE, WD, READY, Data_out, Data_oe, ERR
    );

    modport slave (
        input  Address, BHE_n, Data_in, CS, ALE, RD, WR,
        output OE, WD, READY, Data_out, Data_oe, ERR
    );
endinterface

// File: rtl/iom_wait_ctrl.sv
// -----------------------------------------------------------------------------
// iom_wait_ctrl
// Memory/IO bus-cycle controller for an 8086-style local bus. It sequences
// T1 -> T2 -> (TW x WAIT_STATES) -> R|W -> T4, latches the address on ALE,
// decodes byte lanes from {A0, BHE_n} and owns a byte-addressable memory of
// MEM_WORDS 16-bit words.
//
// Ports
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : iom_wait_ctrl_if.slave
//          in  Address, BHE_n, Data_in, CS, ALE, RD, WR
//          out OE, WD (active low), READY, Data_out, Data_oe, ERR
//
// Optional feature macro: IOM_TIMEOUT_EN
//   Defined   : a T2 that stays idle (RD=WR=1) for TIMEOUT cycles pulses ERR
//               and abandons the cycle back to T1.
//   Undefined : T2 waits indefinitely and no timeout counter exists.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module iom_wait_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 16
) (
    input logic             clk,
    input logic             rst,
    iom_wait_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // One-hot state encoding
    localparam logic [5:0] S_T1 = 6'b000001;
    localparam logic [5:0] S_T2 = 6'b000010;
    localparam logic [5:0] S_TW = 6'b000100;
    localparam logic [5:0] S_R  = 6'b001000;
    localparam logic [5:0] S_W  = 6'b010000;
    localparam logic [5:0] S_T4 = 6'b100000;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    logic [5:0]        r_state;
    logic [ADDR_W-1:0] r_a;
    logic              r_bhe;
    logic              r_tgt_wr;     // recorded target while sitting in TW
    logic [3:0]        r_wcnt;
    logic [DATA_W-1:0] r_dout;
    logic              r_err;

    logic [7:0]        r_mem_lo [MEM_WORDS];
    logic [7:0]        r_mem_hi [MEM_WORDS];

`ifdef IOM_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] r_tcnt;
`endif

    logic [IDX_W-1:0]  w_idx;
    logic              w_lo_en;
    logic              w_hi_en;
    logic [DATA_W-1:0] w_rword;
    logic              w_start;
    logic              w_unused;

    // Address bits above the word index are dropped, so memory aliases.
    assign w_idx   = r_a[IDX_W:1];
    assign w_lo_en = ~r_a[0];
    assign w_hi_en = ~r_bhe;
    // Disabled lanes read as zero.
    assign w_rword = {w_hi_en ? r_mem_hi[w_idx] : 8'h00,
                      w_lo_en ? r_mem_lo[w_idx] : 8'h00};
    assign w_start = bus.CS && bus.ALE;

    // Upper address bits and TIMEOUT (when the timeout is compiled out) are
    // intentionally unused.
    assign w_unused = &{1'b0, r_a, TIMEOUT[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_T1;
            r_a      <= '0;
            r_bhe    <= 1'b1;
            r_tgt_wr <= 1'b0;
            r_wcnt   <= '0;
            r_dout   <= '0;
            r_err    <= 1'b0;
`ifdef IOM_TIMEOUT_EN
            r_tcnt   <= '0;
`endif
        end else begin
            r_err <= 1'b0;
`ifdef IOM_TIMEOUT_EN
            // Cleared by default; only an idle T2 cycle keeps it counting.
            r_tcnt <= '0;
`endif
            case (r_state)
                S_T1: begin
                    if (w_start) begin
                        r_a     <= bus.Address;
                        r_bhe   <= bus.BHE_n;
                        r_state <= S_T2;
                    end
                end
                S_T2: begin
                    if (bus.RD != bus.WR) begin
                        // Exactly one strobe low: WR low means write.
                        r_tgt_wr <= ~bus.WR;
                        r_wcnt   <= WAIT_CNT;
                        if (WAIT_STATES == 0) begin
                            r_state <= bus.WR ? S_R : S_W;
                            if (bus.WR) r_dout <= w_rword;
                        end else begin
                            r_state <= S_TW;
                        end
                    end else if (!bus.RD && !bus.WR) begin
                        r_err   <= 1'b1;
                        r_state <= S_T4;
                    end else begin
`ifdef IOM_TIMEOUT_EN
                        if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                            r_err   <= 1'b1;
                            r_state <= S_T1;
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_W'(1);
                        end
`endif
                    end
                end
                S_TW: begin
                    r_wcnt <= r_wcnt - 4'd1;
                    if (r_wcnt == 4'd1) begin
                        r_state <= r_tgt_wr ? S_W : S_R;
                        if (!r_tgt_wr) r_dout <= w_rword;
                    end
                end
                S_R, S_W: r_state <= S_T4;
                S_T4: begin
                    if (w_start) begin
                        r_a     <= bus.Address;
                        r_bhe   <= bus.BHE_n;
                        r_state <= S_T2;
                    end else begin
                        r_state <= S_T1;
                    end
                end
                default: r_state <= S_T1;
            endcase
        end
    end

    // Memory is not reset; a reset on the edge leaving W drops the write.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_W) begin
            if (w_lo_en) r_mem_lo[w_idx] <= bus.Data_in[7:0];
            if (w_hi_en) r_mem_hi[w_idx] <= bus.Data_in[15:8];
        end
    end

    assign bus.OE       = (r_state != S_R);
    assign bus.WD       = (r_state != S_W);
    assign bus.READY    = (r_state != S_TW);
    assign bus.Data_oe  = (r_state == S_R) || (r_state == S_T4);
    assign bus.Data_out = r_dout;
    assign bus.ERR      = r_err;

endmodule

// File: tb/tb_iom_wait_ctrl.sv
`timescale 1ns/1ps
module tb_iom_wait_ctrl;
    localparam int MW = 16;

    logic        clk, rst;
    logic [19:0] a;
    logic        bhe, cs, ale, rd, wr;
    logic [15:0] din;
    int          sel;
    logic        oe_n, wd_n, ready, doe, err;
    logic [15:0] dout;
    int          errs, checks;

    // Reference memory: plain byte array per DUT, byte address = 2*word + lane.
    logic [7:0]  mdl [0:1][0:2*MW-1];

    iom_wait_ctrl_if #(.ADDR_W(20), .DATA_W(16)) b0 ();
    iom_wait_ctrl_if #(.ADDR_W(20), .DATA_W(16)) b1 ();

    // Only the selected DUT sees an active bus; the other one idles.
    assign b0.Address = a;
    assign b0.BHE_n   = bhe;
    assign b0.Data_in = din;
    assign b0.CS      = cs  && (sel == 0);
    assign b0.ALE     = ale && (sel == 0);
    assign b0.RD      = rd  || (sel != 0);
    assign b0.WR      = wr  || (sel != 0);
    assign b1.Address = a;
    assign b1.BHE_n   = bhe;
    assign b1.Data_in = din;
    assign b1.CS      = cs  && (sel == 1);
    assign b1.ALE     = ale && (sel == 1);
    assign b1.RD      = rd  || (sel != 1);
    assign b1.WR      = wr  || (sel != 1);

    assign oe_n  = (sel != 0) ? b1.OE       : b0.OE;
    assign wd_n  = (sel != 0) ? b1.WD       : b0.WD;
    assign ready = (sel != 0) ? b1.READY    : b0.READY;
    assign doe   = (sel != 0) ? b1.Data_oe  : b0.Data_oe;
    assign err   = (sel != 0) ? b1.ERR      : b0.ERR;
    assign dout  = (sel != 0) ? b1.Data_out : b0.Data_out;

    iom_wait_ctrl #(.ADDR_W(20), .DATA_W(16), .MEM_WORDS(MW), .WAIT_STATES(0), .TIMEOUT(16))
        dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    iom_wait_ctrl #(.ADDR_W(20), .DATA_W(16), .MEM_WORDS(MW), .WAIT_STATES(3), .TIMEOUT(16))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int base_of(input logic [19:0] ad);
        return ((int'(ad) >> 1) % MW) * 2;
    endfunction

    task automatic mdl_write(input int s, input logic [19:0] ad, input logic bh, input logic [15:0] d);
        int b;
        b = base_of(ad);
        if (ad[0] == 1'b0) mdl[s][b]   = d[7:0];
        if (bh == 1'b0)    mdl[s][b+1] = d[15:8];
    endtask

    function automatic logic [15:0] mdl_read(input int s, input logic [19:0] ad, input logic bh);
        logic [15:0] r;
        int b;
        r = 16'h0000;
        b = base_of(ad);
        if (ad[0] == 1'b0) r[7:0]  = mdl[s][b];
        if (bh == 1'b0)    r[15:8] = mdl[s][b+1];
        return r;
    endfunction

    // Runs one complete bus cycle from T1 and returns what was observed.
    // cyc = cycles from T2 to T4 entry. Leaves the DUT in T1.
    task automatic bus_access(input logic w, input logic [19:0] ad, input logic bh,
                              input logic [15:0] d, output logic [15:0] rdat,
                              output int cyc, output int nwait, output int nwd,
                              output int noe, output logic doe_bad, output logic tmo);
        logic seen;
        rdat = 16'h0; cyc = 0; nwait = 0; nwd = 0; noe = 0; doe_bad = 1'b0; tmo = 1'b1;
        seen = 1'b0;
        a = ad; bhe = bh; cs = 1'b1; ale = 1'b1;
        tick;                                   // T2
        cs = 1'b0; ale = 1'b0;
        if (doe) doe_bad = 1'b1;
        if (w) begin wr = 1'b0; din = d; end else rd = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (!ready) nwait++;
            if (!oe_n || !wd_n) begin
                seen = 1'b1; rd = 1'b1; wr = 1'b1;
                if (!oe_n) begin noe++; rdat = dout; if (!doe) doe_bad = 1'b1; end
                if (!wd_n) nwd++;
            end else if (seen) begin
                // T4: Data_oe stays high and read data is held
                if (!doe) doe_bad = 1'b1;
                if (!w && dout !== rdat) doe_bad = 1'b1;
                cyc = i; tmo = 1'b0;
                break;
            end else if (doe) begin
                doe_bad = 1'b1;
            end
        end
        rd = 1'b1; wr = 1'b1;
        tick;                                   // T1
        if (doe) doe_bad = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b0; ale = 1'b0; rd = 1'b1; wr = 1'b1;
        a = '0; bhe = 1'b1; din = '0;
        tick; tick;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            checks++; if (oe_n !== 1'b1)     begin errs++; $display("FAIL reset_oe sel=%0d got=%b exp=1", s, oe_n); end
            checks++; if (wd_n !== 1'b1)     begin errs++; $display("FAIL reset_wd sel=%0d got=%b exp=1", s, wd_n); end
            checks++; if (ready !== 1'b1)    begin errs++; $display("FAIL reset_ready sel=%0d got=%b exp=1", s, ready); end
            checks++; if (dout !== 16'h0)    begin errs++; $display("FAIL reset_dout sel=%0d got=%h exp=0000", s, dout); end
            checks++; if (doe !== 1'b0)      begin errs++; $display("FAIL reset_doe sel=%0d got=%b exp=0", s, doe); end
            checks++; if (err !== 1'b0)      begin errs++; $display("FAIL reset_err sel=%0d got=%b exp=0", s, err); end
        end
        rst = 1'b0;
        sel = 0;
        tick;
    endtask

    task automatic test_write_read;
        logic [15:0] rdat; int cyc, nw, nwd, noe; logic bad, tmo;
        sel = 0;
        bus_access(1'b1, 20'h00010, 1'b0, 16'hBEEF, rdat, cyc, nw, nwd, noe, bad, tmo);
        mdl_write(0, 20'h00010, 1'b0, 16'hBEEF);
        checks++; if (nwd !== 1 || noe !== 0) begin errs++; $display("FAIL wr_strobes wd=%0d oe=%0d exp wd=1 oe=0", nwd, noe); end
        checks++; if (cyc !== 2 || tmo)       begin errs++; $display("FAIL wr_len got=%0d tmo=%b exp=2", cyc, tmo); end
        checks++; if (nw !== 0)               begin errs++; $display("FAIL wr_ready got=%0d exp=0", nw); end
        bus_access(1'b0, 20'h00010, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== 16'hBEEF)      begin errs++; $display("FAIL rd_word got=%h exp=beef", rdat); end
        checks++; if (noe !== 1 || nwd !== 0) begin errs++; $display("FAIL rd_strobes oe=%0d wd=%0d exp oe=1 wd=0", noe, nwd); end
        checks++; if (bad)                    begin errs++; $display("FAIL rd_data_oe got=bad exp=1 only in R,T4"); end
    endtask

    task automatic test_byte_lanes;
        logic [15:0] rdat; int cyc, nw, nwd, noe; logic bad, tmo;
        sel = 0;
        bus_access(1'b1, 20'h00011, 1'b0, 16'h1234, rdat, cyc, nw, nwd, noe, bad, tmo);
        mdl_write(0, 20'h00011, 1'b0, 16'h1234);
        bus_access(1'b0, 20'h00010, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== 16'h12EF) begin errs++; $display("FAIL lane_hi got=%h exp=12ef", rdat); end
        bus_access(1'b1, 20'h00010, 1'b1, 16'hFF00, rdat, cyc, nw, nwd, noe, bad, tmo);
        mdl_write(0, 20'h00010, 1'b1, 16'hFF00);
        bus_access(1'b0, 20'h00010, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== 16'h1200) begin errs++; $display("FAIL lane_lo got=%h exp=1200", rdat); end
        bus_access(1'b0, 20'h00011, 1'b1, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== 16'h0000 || cyc !== 2) begin errs++; $display("FAIL lane_none_rd got=%h len=%0d exp=0000 len=2", rdat, cyc); end
        bus_access(1'b1, 20'h00011, 1'b1, 16'hFFFF, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (nwd !== 1) begin errs++; $display("FAIL lane_none_wr_wd got=%0d exp=1", nwd); end
        bus_access(1'b0, 20'h00011, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== 16'h1200) begin errs++; $display("FAIL lane_hi_rd got=%h exp=1200", rdat); end
        bus_access(1'b0, 20'hF0010, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== 16'h1200) begin errs++; $display("FAIL alias got=%h exp=1200", rdat); end
    endtask

    task automatic test_wait_states;
        logic [15:0] rdat; int cyc, nw, nwd, noe; logic bad, tmo;
        sel = 1;
        bus_access(1'b1, 20'h00006, 1'b0, 16'hA5C3, rdat, cyc, nw, nwd, noe, bad, tmo);
        mdl_write(1, 20'h00006, 1'b0, 16'hA5C3);
        checks++; if (nw !== 3 || cyc !== 5) begin errs++; $display("FAIL ws_wr wait=%0d len=%0d exp wait=3 len=5", nw, cyc); end
        checks++; if (nwd !== 1)             begin errs++; $display("FAIL ws_wr_wd got=%0d exp=1", nwd); end
        bus_access(1'b0, 20'h00006, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (nw !== 3 || cyc !== 5) begin errs++; $display("FAIL ws_rd wait=%0d len=%0d exp wait=3 len=5", nw, cyc); end
        checks++; if (rdat !== 16'hA5C3 || bad) begin errs++; $display("FAIL ws_rd_data got=%h bad=%b exp=a5c3", rdat, bad); end
        sel = 0;
    endtask

    task automatic test_proto_err;
        logic [15:0] rdat; int cyc, nw, nwd, noe; logic bad, tmo;
        sel = 0;
        a = 20'h00010; bhe = 1'b0; cs = 1'b1; ale = 1'b1; din = 16'h5555;
        tick;
        cs = 1'b0; ale = 1'b0; rd = 1'b0; wr = 1'b0;
        tick;
        checks++; if (err !== 1'b1 || doe !== 1'b1 || wd_n !== 1'b1 || oe_n !== 1'b1)
            begin errs++; $display("FAIL perr_t4 err=%b doe=%b wd=%b oe=%b exp 1 1 1 1", err, doe, wd_n, oe_n); end
        rd = 1'b1; wr = 1'b1;
        tick;
        checks++; if (err !== 1'b0 || doe !== 1'b0) begin errs++; $display("FAIL perr_pulse err=%b doe=%b exp 0 0", err, doe); end
        bus_access(1'b0, 20'h00010, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== mdl_read(0, 20'h00010, 1'b0)) begin errs++; $display("FAIL perr_mem got=%h exp=%h", rdat, mdl_read(0, 20'h00010, 1'b0)); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rdat; int cyc, nw, nwd, noe; logic bad, tmo;
        sel = 0;
        a = 20'h00010; bhe = 1'b0; cs = 1'b1; ale = 1'b1;
        tick;
        cs = 1'b0; ale = 1'b0; wr = 1'b0; din = 16'hAAAA;
        tick;
        checks++; if (wd_n !== 1'b0) begin errs++; $display("FAIL rstw_inw wd=%b exp=0", wd_n); end
        rst = 1'b1; wr = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (wd_n !== 1'b1 || oe_n !== 1'b1 || doe !== 1'b0 || ready !== 1'b1)
            begin errs++; $display("FAIL rstw_t1 wd=%b oe=%b doe=%b rdy=%b exp 1 1 0 1", wd_n, oe_n, doe, ready); end
        bus_access(1'b0, 20'h00010, 1'b0, 16'h0, rdat, cyc, nw, nwd, noe, bad, tmo);
        checks++; if (rdat !== mdl_read(0, 20'h00010, 1'b0)) begin errs++; $display("FAIL rstw_mem got=%h exp=%h", rdat, mdl_read(0, 20'h00010, 1'b0)); end
    endtask

    task automatic test_back_to_back;
        sel = 0;
        a = 20'h00004; bhe = 1'b0; cs = 1'b1; ale = 1'b1;
        tick;                                   // T2
        cs = 1'b0; ale = 1'b0; wr = 1'b0; din = 16'h1357;
        tick;                                   // W
        mdl_write(0, 20'h00004, 1'b0, 16'h1357);
        wr = 1'b1;
        tick;                                   // T4
        checks++; if (doe !== 1'b1 || wd_n !== 1'b1) begin errs++; $display("FAIL b2b_t4 doe=%b wd=%b exp 1 1", doe, wd_n); end
        cs = 1'b1; ale = 1'b1;
        tick;                                   // T2 again, no T1
        cs = 1'b0; ale = 1'b0; rd = 1'b0;
        tick;                                   // R
        checks++; if (oe_n !== 1'b0) begin errs++; $display("FAIL b2b_r oe=%b exp=0", oe_n); end
        checks++; if (dout !== 16'h1357) begin errs++; $display("FAIL b2b_data got=%h exp=1357", dout); end
        rd = 1'b1;
        tick; tick;
    endtask

    task automatic test_timeout;
        int n;
        sel = 0; n = 0;
        a = 20'h00010; bhe = 1'b0; cs = 1'b1; ale = 1'b1;
        tick;
        cs = 1'b0; ale = 1'b0;
`ifdef IOM_TIMEOUT_EN
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (err) begin n = i; break; end
        end
        checks++; if (n !== 16) begin errs++; $display("FAIL tmo_len got=%0d exp=16", n); end
        wr = 1'b0; din = 16'h6666;
        tick;
        checks++; if (wd_n !== 1'b1 || err !== 1'b0) begin errs++; $display("FAIL tmo_t1 wd=%b err=%b exp 1 0", wd_n, err); end
        wr = 1'b1;
        tick;
`else
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (err) n++;
        end
        checks++; if (n !== 0) begin errs++; $display("FAIL t2_wait err_cycles=%0d exp=0", n); end
        wr = 1'b0; din = 16'h6666;
        tick;
        checks++; if (wd_n !== 1'b0) begin errs++; $display("FAIL t2_wait_wr wd=%b exp=0", wd_n); end
        mdl_write(0, 20'h00010, 1'b0, 16'h6666);
        wr = 1'b1;
        tick; tick;
`endif
    endtask

    task automatic test_random;
        logic [15:0] rdat, d, exp; logic [19:0] ad; logic bh, w;
        int cyc, nw, nwd, noe; logic bad, tmo;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int k = 0; k < MW; k++) begin
                d = 16'($urandom);
                ad = 20'(k * 2);
                bus_access(1'b1, ad, 1'b0, d, rdat, cyc, nw, nwd, noe, bad, tmo);
                mdl_write(s, ad, 1'b0, d);
            end
            for (int k = 0; k < 40; k++) begin
                ad = 20'($urandom);
                bh = 1'($urandom_range(0, 1));
                w  = 1'($urandom_range(0, 1));
                d  = 16'($urandom);
                bus_access(w, ad, bh, d, rdat, cyc, nw, nwd, noe, bad, tmo);
                checks++; if (cyc !== (s != 0 ? 5 : 2) || tmo)
                    begin errs++; $display("FAIL rnd_len sel=%0d got=%0d tmo=%b", s, cyc, tmo); end
                if (w) begin
                    mdl_write(s, ad, bh, d);
                    checks++; if (nwd !== 1 || noe !== 0) begin errs++; $display("FAIL rnd_wr sel=%0d wd=%0d oe=%0d exp 1 0", s, nwd, noe); end
                end else begin
                    exp = mdl_read(s, ad, bh);
                    checks++; if (rdat !== exp || bad)
                        begin errs++; $display("FAIL rnd_rd sel=%0d a=%h bhe=%b got=%h exp=%h bad=%b", s, ad, bh, rdat, exp, bad); end
                end
            end
        end
        sel = 0;
    endtask

    initial begin
        errs = 0; checks = 0; sel = 0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_proto_err();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
